dff_seq_checker: RTL and testbench

DFF_SEQ_CHECKER -- requirements
Module: dff_seq_checker

---
 rtl/dff_seq_checker.sv | 109 ++++++++++
 tb/tb_dff_seq_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dff_seq_checker.sv
// Checker for the overlapping rule "d=1 at edge N implies d=1 at N+1 and q=1 at N+2".
// Produces registered pass/fail pulses, saturating counters, a sticky error and first-fail timestamp.
module dff_seq_checker #(
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             d,
  input  logic             q,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_kind,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_sticky,
  output logic [TS_W-1:0]  first_fail_ts
);

  logic             r_s1;
  logic             r_s2;
  logic             r_pass;
  logic             r_fail;
  logic [1:0]       r_fail_kind;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_err_sticky;
  logic [TS_W-1:0]  r_first_fail_ts;
  logic             r_cap;
  logic [TS_W-1:0]  r_ts;

  logic             w_pass;
  logic             w_dfail;
  logic             w_qfail;
  logic             w_any_fail;
  logic [1:0]       w_fail_inc;

  // Saturating add: an overflow into the extra bit clamps to all ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    if (sum[CNT_W]) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  // Stage evaluation at the current edge; a low enable suppresses every outcome.
  always_comb begin
    w_pass     = en & r_s2 & q;
    w_qfail    = en & r_s2 & ~q;
    w_dfail    = en & r_s1 & ~d;
    w_any_fail = w_qfail | w_dfail;
    w_fail_inc = {1'b0, w_qfail} + {1'b0, w_dfail};
  end

  // Pipeline stages, pulses, counters, sticky error and timestamps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1            <= 1'b0;
      r_s2            <= 1'b0;
      r_pass          <= 1'b0;
      r_fail          <= 1'b0;
      r_fail_kind     <= 2'b00;
      r_pass_cnt      <= '0;
      r_fail_cnt      <= '0;
      r_err_sticky    <= 1'b0;
      r_first_fail_ts <= '0;
      r_cap           <= 1'b0;
      r_ts            <= '0;
    end else begin
      r_ts        <= r_ts + TS_W'(1);
      r_s1        <= en & d;
      r_s2        <= en & r_s1 & d;
      r_pass      <= w_pass;
      r_fail      <= w_any_fail;
      r_fail_kind <= {w_qfail, w_dfail};
      // Clear beats any same-edge accounting, but the pulses above still fire.
      if (clr) begin
        r_pass_cnt      <= '0;
        r_fail_cnt      <= '0;
        r_err_sticky    <= 1'b0;
        r_first_fail_ts <= '0;
        r_cap           <= 1'b0;
      end else begin
        r_pass_cnt   <= sat_add(r_pass_cnt, {1'b0, w_pass});
        r_fail_cnt   <= sat_add(r_fail_cnt, w_fail_inc);
        r_err_sticky <= r_err_sticky | w_any_fail;
        if (w_any_fail && !r_cap) begin
          r_first_fail_ts <= r_ts;
          r_cap           <= 1'b1;
        end
      end
    end
  end

  assign pass          = r_pass;
  assign fail          = r_fail;
  assign fail_kind     = r_fail_kind;
  assign pass_cnt      = r_pass_cnt;
  assign fail_cnt      = r_fail_cnt;
  assign err_sticky    = r_err_sticky;
  assign first_fail_ts = r_first_fail_ts;

endmodule

// File: tb/tb_dff_seq_checker.sv
// Bench for dff_seq_checker: a rule-level model over the input history, plus literal spot checks.
module tb_dff_seq_checker;

  logic clk = 1'b0;
  logic rst, en, clr, d, q;

  logic        a_pass, a_fail, a_sticky;
  logic [1:0]  a_kind;
  logic [15:0] a_pc, a_fc;
  logic [31:0] a_ff;

  logic        b_pass, b_fail, b_sticky;
  logic [1:0]  b_kind;
  logic [1:0]  b_pc, b_fc;
  logic [31:0] b_ff;

  dff_seq_checker #(.CNT_W(16), .TS_W(32)) u_dut16 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .q(q),
    .pass(a_pass), .fail(a_fail), .fail_kind(a_kind), .pass_cnt(a_pc),
    .fail_cnt(a_fc), .err_sticky(a_sticky), .first_fail_ts(a_ff)
  );

  dff_seq_checker #(.CNT_W(2), .TS_W(32)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .q(q),
    .pass(b_pass), .fail(b_fail), .fail_kind(b_kind), .pass_cnt(b_pc),
    .fail_cnt(b_fc), .err_sticky(b_sticky), .first_fail_ts(b_ff)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Input history per edge; ok = enabled and not in reset.
  bit hd  [0:1023];
  bit hq  [0:1023];
  bit hok [0:1023];
  int k = 2;

  int m_pc16, m_fc16, m_pc2, m_fc2, m_ts, m_ff;
  bit m_sticky, m_cap, m_pass, m_fail;
  bit [1:0] m_kind;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k - 1);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Apply one edge's inputs, advance the model, then compare both DUTs away from the edge.
  task automatic step(input bit i_en, input bit i_clr, input bit i_d, input bit i_q, input bit i_rst);
    bit ep, edf, eqf;
    rst = i_rst; en = i_en; clr = i_clr; d = i_d; q = i_q;
    @(posedge clk);
    hd[k] = i_d; hq[k] = i_q; hok[k] = i_en & ~i_rst;
    if (i_rst) begin
      m_pc16 = 0; m_fc16 = 0; m_pc2 = 0; m_fc2 = 0; m_ts = 0; m_ff = 0;
      m_sticky = 0; m_cap = 0; m_pass = 0; m_fail = 0; m_kind = 2'b00;
    end else begin
      ep  = hok[k] & hok[k-1] & hok[k-2] & hd[k-2] & hd[k-1] & hq[k];
      eqf = hok[k] & hok[k-1] & hok[k-2] & hd[k-2] & hd[k-1] & ~hq[k];
      edf = hok[k] & hok[k-1] & hd[k-1] & ~hd[k];
      m_pass = ep;
      m_fail = edf | eqf;
      m_kind = {eqf, edf};
      if (i_clr) begin
        m_pc16 = 0; m_fc16 = 0; m_pc2 = 0; m_fc2 = 0; m_ff = 0;
        m_sticky = 0; m_cap = 0;
      end else begin
        m_pc16 = sat(m_pc16 + int'(ep), 65535);
        m_fc16 = sat(m_fc16 + int'(edf) + int'(eqf), 65535);
        m_pc2  = sat(m_pc2 + int'(ep), 3);
        m_fc2  = sat(m_fc2 + int'(edf) + int'(eqf), 3);
        if (m_fail) m_sticky = 1;
        if (m_fail && !m_cap) begin
          m_ff = m_ts;
          m_cap = 1;
        end
      end
      m_ts = m_ts + 1;
    end
    k++;
    @(negedge clk);
    chk("pass",       32'(a_pass),   32'(m_pass));
    chk("fail",       32'(a_fail),   32'(m_fail));
    chk("fail_kind",  32'(a_kind),   32'(m_kind));
    chk("pass_cnt",   32'(a_pc),     32'(m_pc16));
    chk("fail_cnt",   32'(a_fc),     32'(m_fc16));
    chk("err_sticky", 32'(a_sticky), 32'(m_sticky));
    chk("first_ts",   a_ff,          32'(m_ff));
    chk("w2_pass",    32'(b_pass),   32'(m_pass));
    chk("w2_fail",    32'(b_fail),   32'(m_fail));
    chk("w2_kind",    32'(b_kind),   32'(m_kind));
    chk("w2_pass_cnt",32'(b_pc),     32'(m_pc2));
    chk("w2_fail_cnt",32'(b_fc),     32'(m_fc2));
    chk("w2_sticky",  32'(b_sticky), 32'(m_sticky));
    chk("w2_first_ts",b_ff,          32'(m_ff));
  endtask

  task automatic do_rst();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [63:0] pat_d, pat_q;
    rst = 1'b1; en = 1'b0; clr = 1'b0; d = 1'b0; q = 1'b0;
    do_rst();
    do_rst();
    chk("reset_pass_cnt", 32'(a_pc), 32'd0);
    chk("reset_sticky",   32'(a_sticky), 32'd0);

    // Overlapping attempts: passes at edges 3 and 4, d-stage fail at 4.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ov_no_pass_e2", 32'(a_pass), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ov_pass_e3", 32'(a_pass), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ov_pass_cnt", 32'(a_pc), 32'd2);
    chk("ov_fail_cnt", 32'(a_fc), 32'd1);
    chk("ov_kind",     32'(a_kind), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // First-fail timestamp: d=1 at ts=5, d=0 at ts=6.
    do_rst();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ts_kind",   32'(a_kind),   32'd1);
    chk("ts_first",  a_ff,          32'd6);
    chk("ts_sticky", 32'(a_sticky), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ts_keep",   a_ff,          32'd6);
    chk("ts_fcnt",   32'(a_fc),     32'd2);

    // Both stages fail on the same edge.
    do_rst();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dbl_kind", 32'(a_kind), 32'd3);
    chk("dbl_fcnt", 32'(a_fc),   32'd2);
    chk("dbl_pass", 32'(a_pass), 32'd0);

    // Two-bit counter saturation and clear.
    do_rst();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sat_fcnt", 32'(b_fc), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("clr_fcnt",   32'(b_fc),     32'd0);
    chk("clr_sticky", 32'(b_sticky), 32'd0);

    // +2 from max-1 clamps to max.
    do_rst();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clamp_fcnt", 32'(b_fc), 32'd3);
    chk("clamp_16",   32'(a_fc), 32'd4);

    // Clear on an edge with pulses: pulses fire, counts stay zero.
    do_rst();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("clrp_pass", 32'(a_pass), 32'd1);
    chk("clrp_fail", 32'(a_fail), 32'd1);
    chk("clrp_pcnt", 32'(a_pc),   32'd0);

    // Enable drop flushes the pending attempt.
    do_rst();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("en_fail", 32'(a_fail), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("en_fcnt", 32'(a_fc), 32'd0);

    // Reset mid-attempt discards it.
    do_rst();
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_fail", 32'(a_fail), 32'd0);
    end

    // Mixed traffic checked against the model only.
    pat_d = 64'hF3B7_6E1D_C9FA_57E3;
    pat_q = 64'hDB6F_A5CE_7F39_B1EE;
    for (int i = 0; i < 64; i++) begin
      step((i % 13) != 7, (i == 30), pat_d[i], pat_q[i], 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
